// File: rtl/crc_frame_seq.sv
// crc_frame_seq: byte-stream front end for a bit-serial CRC32-MPEG2 engine.
// Accepts framed bytes, clears the engine at each frame start, shifts each
// byte into the engine MSB-first, then captures and reports the frame CRC.
//
// Handshake: a byte transfers on a rising clk edge where axiiv && axiir.
// The upstream source holds axiiv/axiid/axiil stable until that edge.
// axiir is high only in IDLE, and is forced low while abort is asserted.
module crc_frame_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [7:0]       axiid,
  input  logic             axiil,
  output logic             axiir,
  input  logic             abort,
  output logic             crc_rst,
  output logic             crc_axiiv,
  output logic             crc_axiid,
  input  logic             crc_axiov,
  input  logic [31:0]      crc_axiod,
  output logic [31:0]      crc_out,
  output logic             crc_valid,
  output logic             frame_ok,
  output logic             crc_err,
  output logic [CNT_W-1:0] byte_cnt,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic             ready_q;
  logic             frame_active;
  logic [7:0]       byte_q;
  logic             last_q;
  logic [2:0]       bit_idx;
  logic [CNT_W-1:0] count;
  logic             accept;

  // Ready is registered (high in IDLE) but abort blocks acceptance at once.
  assign axiir     = ready_q & ~abort;
  assign accept    = axiiv & axiir;
  assign state_dbg = state;

  // Sequencer: state, engine drive and result capture, all registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      frame_active <= 1'b0;
      byte_q       <= '0;
      last_q       <= 1'b0;
      bit_idx      <= '0;
      count        <= '0;
      crc_rst      <= 1'b1;
      crc_axiiv    <= 1'b0;
      crc_axiid    <= 1'b0;
      crc_valid    <= 1'b0;
      crc_out      <= '0;
      frame_ok     <= 1'b0;
      crc_err      <= 1'b0;
      byte_cnt     <= '0;
    end else if (abort) begin
      // Drop the frame: engine is cleared and no result is reported.
      state        <= IDLE;
      ready_q      <= 1'b1;
      frame_active <= 1'b0;
      count        <= '0;
      bit_idx      <= '0;
      crc_rst      <= 1'b1;
      crc_axiiv    <= 1'b0;
      crc_axiid    <= 1'b0;
      crc_valid    <= 1'b0;
    end else begin
      crc_rst   <= 1'b0;
      crc_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            byte_q  <= axiid;
            last_q  <= axiil;
            count   <= (count == {CNT_W{1'b1}}) ? count : count + 1'b1;
            ready_q <= 1'b0;
            if (!frame_active) begin
              // First byte of a frame: clear the engine before shifting.
              state        <= CLR;
              frame_active <= 1'b1;
              crc_rst      <= 1'b1;
            end else begin
              state     <= SHIFT;
              bit_idx   <= '0;
              crc_axiiv <= 1'b1;
              crc_axiid <= axiid[7];
            end
          end
        end
        CLR: begin
          state     <= SHIFT;
          bit_idx   <= '0;
          crc_axiiv <= 1'b1;
          crc_axiid <= byte_q[7];
        end
        SHIFT: begin
          if (bit_idx == 3'd7) begin
            crc_axiiv <= 1'b0;
            crc_axiid <= 1'b0;
            if (last_q) begin
              state <= WAIT;
            end else begin
              state   <= IDLE;
              ready_q <= 1'b1;
            end
          end else begin
            // Present the next bit so the engine sees bit 7-b on SHIFT cycle b.
            bit_idx   <= bit_idx + 3'd1;
            crc_axiid <= byte_q[3'd6 - bit_idx];
          end
        end
        WAIT: begin
          // Engine has absorbed the final bit; its output is the frame CRC.
          crc_out   <= crc_axiod;
          frame_ok  <= crc_axiov && (crc_axiod == 32'h0);
          crc_err   <= !crc_axiov;
          byte_cnt  <= count;
          crc_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          frame_active <= 1'b0;
          count        <= '0;
          ready_q      <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_seq.sv
// Bench for crc_frame_seq: includes a behavioural CRC32-MPEG2 engine,
// a frame-level reference model and a per-cycle compare process.
module tb_crc_frame_seq;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [31:0] crc;
    logic        ok;
    logic        err;
    logic [15:0] cnt;
    int          cyc;
  } res_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, axiiv, axiil, abort;
  logic [7:0]  axiid;
  logic        axiir, crc_rst, crc_axiiv, crc_axiid, crc_axiov;
  logic [31:0] crc_axiod, crc_out;
  logic        crc_valid, frame_ok, crc_err;
  logic [15:0] byte_cnt;
  logic [2:0]  state_dbg;

  crc_frame_seq #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiil(axiil),
    .axiir(axiir), .abort(abort), .crc_rst(crc_rst), .crc_axiiv(crc_axiiv),
    .crc_axiid(crc_axiid), .crc_axiov(crc_axiov), .crc_axiod(crc_axiod),
    .crc_out(crc_out), .crc_valid(crc_valid), .frame_ok(frame_ok),
    .crc_err(crc_err), .byte_cnt(byte_cnt), .state_dbg(state_dbg)
  );

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- engine model ----------------
  logic [31:0] eng_crc;
  logic        eng_ov;
  bit          engine_fault = 1'b0;

  always @(posedge clk) begin
    if (crc_rst) begin
      eng_crc <= 32'hFFFF_FFFF;
      eng_ov  <= 1'b0;
    end else if (crc_axiiv) begin
      eng_crc <= {eng_crc[30:0], 1'b0} ^ ((eng_crc[31] ^ crc_axiid) ? POLY : 32'h0);
      eng_ov  <= 1'b1;
    end else begin
      eng_ov <= 1'b0;
    end
  end
  assign crc_axiod = eng_crc;
  assign crc_axiov = eng_ov & ~engine_fault;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_of(input bytes_t b);
    logic [31:0] c;
    logic [7:0]  v;
    logic        fb;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      v = b[i];
      for (int k = 7; k >= 0; k--) begin
        fb = c[31] ^ v[k];
        c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  logic [7:0] frame_q[$];
  logic       bit_q[$];
  res_t       res_q[$];
  logic       exp_rst_next;
  bit         chk_en = 1'b0;
  int         run = 0;
  int         first_acc_cyc = 0;
  int         last_acc_cyc = 0;

  // Per-cycle compare against the frame-level model, then model update.
  always @(negedge clk) begin
    logic acc, first;
    res_t r;
    if (chk_en) begin
      check("crc_rst", crc_rst, exp_rst_next);
      if (res_q.size() > 0 && res_q[0].cyc == cyc) begin
        check("crc_valid", crc_valid, 1'b1);
        check("crc_out", crc_out, res_q[0].crc);
        check("frame_ok", frame_ok, res_q[0].ok);
        check("crc_err", crc_err, res_q[0].err);
        check("byte_cnt", byte_cnt, res_q[0].cnt);
        void'(res_q.pop_front());
      end else begin
        check("crc_valid_idle", crc_valid, 1'b0);
      end
      if (crc_axiiv === 1'b1) begin
        if (bit_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL engine_bit: unexpected bit at cycle %0d", cyc);
        end else begin
          check("engine_bit", crc_axiid, bit_q.pop_front());
        end
        run++;
      end else if (run > 0) begin
        check("bit_run", run, 8);
        run = 0;
      end
    end
    acc   = rst && !abort && axiiv && axiir;
    first = (frame_q.size() == 0);
    exp_rst_next = !rst || abort || (acc && first);
    if (!rst || abort) begin
      frame_q.delete(); bit_q.delete(); res_q.delete();
      run = 0;
    end else if (acc) begin
      if (first) first_acc_cyc = cyc;
      else check("acc_gap", cyc - last_acc_cyc, (frame_q.size() == 1) ? 10 : 9);
      last_acc_cyc = cyc;
      frame_q.push_back(axiid);
      for (int k = 7; k >= 0; k--) bit_q.push_back(axiid[k]);
      if (axiil) begin
        r.crc = crc_of(frame_q);
        r.err = engine_fault;
        r.ok  = !engine_fault && (r.crc == 32'h0);
        r.cnt = (frame_q.size() > 65535) ? 16'hFFFF : 16'(frame_q.size());
        r.cyc = cyc + (first ? 11 : 10);
        res_q.push_back(r);
        frame_q.delete();
      end
    end
    chk_en = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input bytes_t b, input bit with_last);
    for (int i = 0; i < b.size(); i++) begin
      int n;
      bit got;
      n = 0; got = 1'b0;
      axiiv = 1'b1;
      axiid = b[i];
      axiil = with_last && (i == b.size() - 1);
      while (!got && n < 40) begin
        @(negedge clk);
        if (axiir) got = 1'b1;
        n++;
        @(posedge clk); #1;
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL accept: byte %0d not accepted within 40 cycles", i);
      end
    end
    axiiv = 1'b0;
    axiil = 1'b0;
  endtask

  task automatic wait_valid(output int vc);
    int n;
    n = 0; vc = -1;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (crc_valid === 1'b1) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) begin
      checks++; failures++;
      $display("FAIL wait_valid: crc_valid not seen within 300 cycles");
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // ---------------- directed stimulus ----------------
  bytes_t f8, f12, f_abort, f_one, f_zero;
  int vc;

  initial begin
    f8     = '{8'hce, 8'h2e, 8'h88, 8'hd9, 8'hb8, 8'hbc, 8'h75, 8'hde};
    f12    = '{8'hce, 8'h2e, 8'h88, 8'hd9, 8'hb8, 8'hbc, 8'h75, 8'hde,
               8'h0d, 8'ha2, 8'h57, 8'hed};
    f_abort = '{8'hce, 8'h2e};
    f_one   = '{8'hce};
    f_zero  = '{8'h00};
    rst = 1'b0; axiiv = 1'b0; axiid = 8'h00; axiil = 1'b0; abort = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_axiir", axiir, 1'b1);
    check("rst_crc_rst", crc_rst, 1'b1);
    check("rst_crc_axiiv", crc_axiiv, 1'b0);
    check("rst_crc_valid", crc_valid, 1'b0);
    check("rst_crc_out", crc_out, 32'h0);
    check("rst_byte_cnt", byte_cnt, 16'h0);
    check("rst_frame_ok", frame_ok, 1'b0);
    check("rst_crc_err", crc_err, 1'b0);
    next_cycle();
    rst = 1'b1;
    next_cycle();

    // Generate: 8-byte frame with continuous valid
    send(f8, 1'b1);
    wait_valid(vc);
    check("gen_latency", vc - first_acc_cyc, 74);
    check("gen_crc", crc_out, 32'h0da257ed);
    check("gen_ok", frame_ok, 1'b0);
    check("gen_err", crc_err, 1'b0);
    check("gen_cnt", byte_cnt, 16'd8);
    next_cycle();
    check("gen_hold_crc", crc_out, 32'h0da257ed);

    // Residue: FCS appended, twice back to back
    for (int rep = 0; rep < 2; rep++) begin
      send(f12, 1'b1);
      wait_valid(vc);
      check("res_crc", crc_out, 32'h0);
      check("res_ok", frame_ok, 1'b1);
      check("res_cnt", byte_cnt, 16'd12);
      next_cycle();
    end

    // Abort during SHIFT of the second byte, then abort in IDLE with a byte
    send(f_abort, 1'b0);
    repeat (3) next_cycle();
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    check("abort_crc_rst", crc_rst, 1'b1);
    check("abort_axiir", axiir, 1'b1);
    next_cycle();
    abort = 1'b1; axiiv = 1'b1; axiid = 8'h55; axiil = 1'b1;
    @(negedge clk);
    check("abort_idle_axiir", axiir, 1'b0);
    next_cycle();
    abort = 1'b0; axiiv = 1'b0; axiil = 1'b0;
    send(f8, 1'b1);
    wait_valid(vc);
    check("abort_next_latency", vc - first_acc_cyc, 74);
    check("abort_next_crc", crc_out, 32'h0da257ed);
    check("abort_next_cnt", byte_cnt, 16'd8);
    next_cycle();

    // Reset mid-frame during SHIFT
    send(f_one, 1'b0);
    repeat (4) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_axiir", axiir, 1'b1);
    check("midrst_crc_axiiv", crc_axiiv, 1'b0);
    check("midrst_crc_valid", crc_valid, 1'b0);
    check("midrst_crc_rst", crc_rst, 1'b1);
    check("midrst_crc_out", crc_out, 32'h0);
    next_cycle();
    send(f8, 1'b1);
    wait_valid(vc);
    check("midrst_next_crc", crc_out, 32'h0da257ed);
    check("midrst_next_cnt", byte_cnt, 16'd8);
    next_cycle();

    // Engine fault: axiov held low, single-byte frame
    engine_fault = 1'b1;
    send(f_zero, 1'b1);
    wait_valid(vc);
    check("fault_latency", vc - first_acc_cyc, 11);
    check("fault_err", crc_err, 1'b1);
    check("fault_ok", frame_ok, 1'b0);
    check("fault_cnt", byte_cnt, 16'd1);
    next_cycle();
    engine_fault = 1'b0;

    repeat (20) next_cycle();
    @(negedge clk);
    check("pending_results", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crc_frame_seq.md
Name: crc_frame_seq

Overview:
- Byte-stream front end and sequencer for the bit-serial CRC32-MPEG2 engine (`crc`: clk, rst, axiiv, axiid, axiov, axiod[31:0]).
- Accepts bytes with a last flag and clears the engine at the start of each frame.
- Serialises each byte MSB-first into the engine, then captures the final CRC and reports it with a residue-zero check.
- Sits between the packet byte path and the engine; the engine is instantiated outside this block and wired to the crc_* ports.

Parameters:
CNT_W, 16, width of frame byte counter (saturates at all-ones)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
axiiv  in  1  input byte valid
axiid  in  8  input byte
axiil  in  1  last byte of frame, qualified by axiiv
axiir  out  1  ready; byte accepted on axiiv && axiir
abort  in  1  drop current frame
crc_rst  out  1  engine reset, active-high
crc_axiiv  out  1  engine bit valid
crc_axiid  out  1  engine bit
crc_axiov  in  1  engine output valid
crc_axiod  in  32  engine CRC
crc_out  out  32  captured CRC of frame
crc_valid  out  1  one-cycle pulse, crc_out/frame_ok/crc_err/byte_cnt valid
frame_ok  out  1  crc_out == 0 (FCS-included frame passes)
crc_err  out  1  engine reported axiov low at capture
byte_cnt  out  CNT_W  bytes in completed frame

Behaviour:
- Reset (rst=0 at posedge): state IDLE, frame_active=0, crc_rst=1.
  - All other outputs reset to 0 except axiir=1; byte_cnt=0, crc_out=0.
- States:
  - IDLE: axiir=1. On accept: latch byte, last, incr count.
    - If !frame_active: go CLR and set frame_active.
    - Else go SHIFT.
  - CLR: one cycle, crc_rst=1, crc_axiiv=0. Go SHIFT.
  - SHIFT: 8 cycles, bit counter b=0..7.
    - crc_axiiv=1, crc_axiid=byte[7-b].
    - At b=7: if last go WAIT, else go IDLE.
  - WAIT: one cycle, crc_axiiv=0.
    - Capture crc_out<=crc_axiod, frame_ok<=(crc_axiod==0), crc_err<=!crc_axiov, byte_cnt<=count.
    - Go DONE.
  - DONE: crc_valid=1 for exactly this cycle. Clear frame_active and count. Go IDLE.
- axiir is low in CLR/SHIFT/WAIT/DONE.
  - Upstream holds axiiv/axiid/axiil; no byte is lost or duplicated.
- crc_axiiv/crc_axiid are registered outputs, so engine sees each bit exactly one cycle per SHIFT cycle.
- crc_rst is 0 outside reset, CLR and abort.
- Latency:
  - First byte: accept cycle, CLR, 8 SHIFT cycles.
  - Each later byte: 9 cycles, accept + 8 SHIFT.
  - Last SHIFT cycle at T gives WAIT at T+1 and crc_valid at T+2.
- Count: increments per accepted byte, saturates at 2^CNT_W-1, zero-length frames impossible.
- Output hold: crc_out/frame_ok/crc_err/byte_cnt hold until next capture; only crc_valid pulses.
- abort (any state, priority below rst):
  - Next state IDLE, crc_rst=1 for one cycle, frame_active=0, count=0, no crc_valid.
  - A byte presented with abort in IDLE is not accepted (axiir forced 0 that cycle).
- axiil on a byte while in IDLE with frame_active=0 gives a single-byte frame: CLR, SHIFT, WAIT, DONE.
- crc_axiov low at WAIT: crc_err=1, frame_ok=0 regardless of crc_axiod.

Test Plan:
- Generate: after reset, frame bytes ce 2e 88 d9 b8 bc 75 de (last on de), axiiv held.
  - crc_valid exactly once, at cycle 74 after first accept.
  - crc_out=32'h0da257ed, frame_ok=0, crc_err=0, byte_cnt=8.
- Residue: same 8 bytes followed by 0d a2 57 ed (last on ed).
  - crc_out=0, frame_ok=1, byte_cnt=12.
  - A second identical frame back-to-back gives the same result, proving CLR between frames.
- Backpressure: axiiv held high continuously.
  - axiir high exactly one cycle per byte (9-cycle period after first).
  - Engine bit sequence equals input MSB-first with no gaps inside a byte.
- Abort: send ce 2e, assert abort during SHIFT of 2e, then send the 8-byte frame.
  - No crc_valid for the aborted frame; crc_rst pulses.
  - Next result 32'h0da257ed, byte_cnt=8.
- Reset mid-frame: rst=0 for one cycle during SHIFT.
  - axiir=1, crc_axiiv=0, crc_valid=0, crc_rst=1.
  - A following full frame is correct.
- Engine fault: tie crc_axiov=0, send single byte 00 with last.
  - crc_err=1, frame_ok=0, byte_cnt=1.
